// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: decodes the ID opcode into a control bundle and walks it through ID/EX, EX/MEM, MEM/WB.
// Latency: decode lands on ex_* one edge after ID, mem_* after two, wb_* after three; pc_write/ifid_* are combinational.
// Backpressure: mem_ready=0 freezes all control registers and drops pc_write/ifid_write; hazards hold PC and IF/ID while a bubble enters EX.
//
// Ports:
//   clk, reset               core clock, asynchronous active-high reset
//   id_valid, id_opcode      ID-stage instruction valid and instr[6:0]
//   id_rs1, id_rs2, id_rd    ID-stage register addresses
//   ex_redirect              EX resolved a taken branch / JAL / JALR
//   mem_ready                data memory completes this cycle
//   pc_write, ifid_write     PC and IF/ID register enables
//   ifid_flush               clear IF/ID to a NOP
//   ex_*                     ID/EX control (alusrc, aluop, branch, jump, jalrsel, rd)
//   mem_*                    EX/MEM control (memread, memwrite, regwrite, rd)
//   wb_*                     MEM/WB control (regwrite, memtoreg, pcsel, rd)
//   stall_count              saturating count of cycles with pc_write=0
//   fwd_a, fwd_b             forwarding selects for EX operands
//
// Build option: define FORWARD_EN to drive fwd_a/fwd_b from the EX/MEM and MEM/WB
// destinations and stall only on load-use. Without it the selects are tied to 00 and
// ID also stalls on any RAW match against a writing instruction in EX or MEM.

module pipe_ctrl_unit #(
    parameter int REG_AW      = 5,
    parameter int ALUOP_W     = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [6:0]             id_opcode,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   ex_redirect,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   ex_alusrc,
    output logic [ALUOP_W-1:0]     ex_aluop,
    output logic                   ex_branch,
    output logic                   ex_jump,
    output logic                   ex_jalrsel,
    output logic [REG_AW-1:0]      ex_rd,
    output logic                   mem_memread,
    output logic                   mem_memwrite,
    output logic                   mem_regwrite,
    output logic [REG_AW-1:0]      mem_rd,
    output logic                   wb_regwrite,
    output logic                   wb_memtoreg,
    output logic                   wb_pcsel,
    output logic [REG_AW-1:0]      wb_rd,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b
);

    // RV32I major opcodes
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // ALUOp codes, zero-extended when ALUOP_W is wider than 2
    localparam logic [ALUOP_W-1:0] ALU_MEM = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_BR  = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_RI  = ALUOP_W'(2'b10);
    localparam logic [ALUOP_W-1:0] ALU_JMP = ALUOP_W'(2'b11);

    // Full bundle held in ID/EX; later stages keep only what they still consume.
    typedef struct packed {
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               branch;
        logic               jump;
        logic               jalrsel;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
        logic               pcsel;
        logic [REG_AW-1:0]  rd;
    } idex_t;

    typedef struct packed {
        logic              memread;
        logic              memwrite;
        logic              regwrite;
        logic              memtoreg;
        logic              pcsel;
        logic [REG_AW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              pcsel;
        logic [REG_AW-1:0] rd;
    } memwb_t;

    idex_t  id_dec;
    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;

    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic                   redir_pend_d, redir_pend_q;

    logic ex_hit;
    logic load_use;
    logic hazard;
    logic redirect_now;

    // ------------------------------------------------------------------
    // ID decode. Unknown opcodes and invalid slots become an all-zero
    // bubble; rd is zeroed for non-writing instructions so downstream
    // hazard/forward compares never need to look at regwrite.
    // ------------------------------------------------------------------
    always_comb begin
        id_dec = '0;
        if (id_valid) begin
            case (id_opcode)
                OP_R: begin
                    id_dec.regwrite = 1'b1;
                    id_dec.aluop    = ALU_RI;
                end
                OP_I: begin
                    id_dec.alusrc   = 1'b1;
                    id_dec.regwrite = 1'b1;
                    id_dec.aluop    = ALU_RI;
                end
                OP_LW: begin
                    id_dec.alusrc   = 1'b1;
                    id_dec.memread  = 1'b1;
                    id_dec.memtoreg = 1'b1;
                    id_dec.regwrite = 1'b1;
                    id_dec.aluop    = ALU_MEM;
                end
                OP_SW: begin
                    id_dec.alusrc   = 1'b1;
                    id_dec.memwrite = 1'b1;
                    id_dec.aluop    = ALU_MEM;
                end
                OP_BR: begin
                    id_dec.branch   = 1'b1;
                    id_dec.aluop    = ALU_BR;
                end
                OP_JAL: begin
                    id_dec.jump     = 1'b1;
                    id_dec.regwrite = 1'b1;
                    id_dec.pcsel    = 1'b1;
                    id_dec.aluop    = ALU_JMP;
                end
                OP_JALR: begin
                    id_dec.alusrc   = 1'b1;
                    id_dec.jalrsel  = 1'b1;
                    id_dec.regwrite = 1'b1;
                    id_dec.pcsel    = 1'b1;
                    id_dec.aluop    = ALU_JMP;
                end
                OP_LUI, OP_AUIPC: begin
                    id_dec.alusrc   = 1'b1;
                    id_dec.regwrite = 1'b1;
                    id_dec.aluop    = ALU_MEM;
                end
                default: ;
            endcase
        end
        if (id_dec.regwrite) begin
            id_dec.rd = id_rd;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection. A nonzero rd already implies RegWrite, so x0 and
    // non-writing instructions never raise a hazard.
    // ------------------------------------------------------------------
    assign ex_hit   = (idex_q.rd != '0) && ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));
    assign load_use = id_valid && idex_q.memread && ex_hit;

`ifdef FORWARD_EN
    assign hazard = load_use;
`else
    logic mem_hit;
    assign mem_hit = (exmem_q.rd != '0) && ((exmem_q.rd == id_rs1) || (exmem_q.rd == id_rs2));
    // Without forwarding the consumer waits until the producer reaches WB.
    assign hazard  = id_valid && (ex_hit || mem_hit);
`endif

    // A redirect seen during a freeze is remembered so it still fires on
    // the first ready cycle even if EX stops asserting it.
    assign redirect_now = mem_ready && (ex_redirect || redir_pend_q);

    // ------------------------------------------------------------------
    // Pipeline advance. Priority: freeze > flush > hazard stall.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_d       = id_dec;
        exmem_d      = '{memread:  idex_q.memread,
                         memwrite: idex_q.memwrite,
                         regwrite: idex_q.regwrite,
                         memtoreg: idex_q.memtoreg,
                         pcsel:    idex_q.pcsel,
                         rd:       idex_q.rd};
        memwb_d      = '{regwrite: exmem_q.regwrite,
                         memtoreg: exmem_q.memtoreg,
                         pcsel:    exmem_q.pcsel,
                         rd:       exmem_q.rd};
        redir_pend_d = 1'b0;

        if (!mem_ready) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_d       = idex_q;
            exmem_d      = exmem_q;
            memwb_d      = memwb_q;
            redir_pend_d = redir_pend_q || ex_redirect;
        end else if (redirect_now) begin
            // Wrong-path instruction in ID is squashed; EX proceeds normally.
            ifid_flush = 1'b1;
            idex_d     = '0;
        end else if (hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_d     = '0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
            stall_cnt_q  <= '0;
            redir_pend_q <= 1'b0;
        end else begin
            idex_q       <= idex_d;
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
            stall_cnt_q  <= stall_cnt_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding selects: 10 = from EX/MEM (youngest wins), 01 = from MEM/WB.
    // ------------------------------------------------------------------
`ifdef FORWARD_EN
    logic [REG_AW-1:0] id_src1, id_src2;
    logic [REG_AW-1:0] ex_rs1_d, ex_rs1_q;
    logic [REG_AW-1:0] ex_rs2_d, ex_rs2_q;

    // Source addresses travel with the bundle; bubbles carry x0 so they
    // never select a forward path.
    assign id_src1 = (id_dec != '0) ? id_rs1 : '0;
    assign id_src2 = (id_dec != '0) ? id_rs2 : '0;

    always_comb begin
        ex_rs1_d = id_src1;
        ex_rs2_d = id_src2;
        if (!mem_ready) begin
            ex_rs1_d = ex_rs1_q;
            ex_rs2_d = ex_rs2_q;
        end else if (redirect_now || hazard) begin
            ex_rs1_d = '0;
            ex_rs2_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
        end else begin
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
        end
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if ((exmem_q.rd != '0) && (exmem_q.rd == ex_rs1_q)) begin
            fwd_a = 2'b10;
        end else if ((memwb_q.rd != '0) && (memwb_q.rd == ex_rs1_q)) begin
            fwd_a = 2'b01;
        end
        if ((exmem_q.rd != '0) && (exmem_q.rd == ex_rs2_q)) begin
            fwd_b = 2'b10;
        end else if ((memwb_q.rd != '0) && (memwb_q.rd == ex_rs2_q)) begin
            fwd_b = 2'b01;
        end
    end
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign ex_alusrc    = idex_q.alusrc;
    assign ex_aluop     = idex_q.aluop;
    assign ex_branch    = idex_q.branch;
    assign ex_jump      = idex_q.jump;
    assign ex_jalrsel   = idex_q.jalrsel;
    assign ex_rd        = idex_q.rd;

    assign mem_memread  = exmem_q.memread;
    assign mem_memwrite = exmem_q.memwrite;
    assign mem_regwrite = exmem_q.regwrite;
    assign mem_rd       = exmem_q.rd;

    assign wb_regwrite  = memwb_q.regwrite;
    assign wb_memtoreg  = memwb_q.memtoreg;
    assign wb_pcsel     = memwb_q.pcsel;
    assign wb_rd        = memwb_q.rd;

    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;

    localparam int AW = 5;
    localparam int AL = 2;
    localparam int CW = 6;   // narrow counter so saturation is reached in the random phase
    localparam int unsigned STALL_MAX = (1 << CW) - 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    logic clk = 1'b0;
    logic reset;
    logic id_valid;
    logic [6:0] id_opcode;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic ex_redirect, mem_ready;
    logic pc_write, ifid_write, ifid_flush;
    logic ex_alusrc, ex_branch, ex_jump, ex_jalrsel;
    logic [AL-1:0] ex_aluop;
    logic [AW-1:0] ex_rd, mem_rd, wb_rd;
    logic mem_memread, mem_memwrite, mem_regwrite;
    logic wb_regwrite, wb_memtoreg, wb_pcsel;
    logic [CW-1:0] stall_count;
    logic [1:0] fwd_a, fwd_b;

    pipe_ctrl_unit #(.REG_AW(AW), .ALUOP_W(AL), .STALL_CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_jalrsel(ex_jalrsel), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_pcsel(wb_pcsel), .wb_rd(wb_rd),
        .stall_count(stall_count), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    // Reference model: one decoded record per pipeline stage.
    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic       branch, jump, jalrsel, memread, memwrite, regwrite, memtoreg, pcsel;
        logic [4:0] rd, rs1, rs2;
    } rec_t;

    rec_t        m_ex, m_mem, m_wb;
    int unsigned m_stalls;
    bit          m_pend;
    bit          e_pc, e_ifw, e_fl;
    int          n_cmp = 0;
    int          n_err = 0;

    // Control table: {alusrc,branch,jump,jalrsel,memread,memwrite,regwrite,memtoreg,pcsel}
    function automatic rec_t dec(input bit v, input bit [6:0] op,
                                 input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd);
        rec_t     r;
        bit [8:0] f;
        bit [1:0] a;
        r = '0; f = '0; a = 2'b00;
        case (op)
            OP_R:           begin f = 9'b000000100; a = 2'b10; end
            OP_I:           begin f = 9'b100000100; a = 2'b10; end
            OP_LW:          begin f = 9'b100010110; a = 2'b00; end
            OP_SW:          begin f = 9'b100001000; a = 2'b00; end
            OP_BR:          begin f = 9'b010000000; a = 2'b01; end
            OP_JAL:         begin f = 9'b001000101; a = 2'b11; end
            OP_JALR:        begin f = 9'b100100101; a = 2'b11; end
            OP_LUI, OP_AUI: begin f = 9'b100000100; a = 2'b00; end
            default:        begin f = '0; a = 2'b00; end
        endcase
        if (!v) begin f = '0; a = 2'b00; end
        {r.alusrc, r.branch, r.jump, r.jalrsel, r.memread, r.memwrite,
         r.regwrite, r.memtoreg, r.pcsel} = f;
        r.aluop = a;
        r.rd    = f[2] ? rd : 5'd0;
        r.rs1   = (f != 0) ? rs1 : 5'd0;
        r.rs2   = (f != 0) ? rs2 : 5'd0;
        return r;
    endfunction

    function automatic bit [1:0] fsel(input bit [4:0] rs);
`ifdef FORWARD_EN
        if (m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
        if (m_wb.rd != 0 && m_wb.rd == rs) return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_stalls = 0; m_pend = 0;
    endtask

    // One cycle: drive at negedge, check just after, advance model, cross posedge.
    task automatic step(input bit v, input bit [6:0] op, input bit [4:0] rs1,
                        input bit [4:0] rs2, input bit [4:0] rd,
                        input bit redir, input bit mr);
        bit lu, hz;
        id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        ex_redirect = redir; mem_ready = mr;
        #1;
        lu = v && m_ex.memread && m_ex.rd != 0 && (m_ex.rd == rs1 || m_ex.rd == rs2);
`ifdef FORWARD_EN
        hz = lu;
`else
        hz = lu || (v && ((m_ex.rd != 0 && (m_ex.rd == rs1 || m_ex.rd == rs2)) ||
                          (m_mem.rd != 0 && (m_mem.rd == rs1 || m_mem.rd == rs2))));
`endif
        if (!mr)                    begin e_pc = 0; e_ifw = 0; e_fl = 0; end
        else if (redir || m_pend)   begin e_pc = 1; e_ifw = 1; e_fl = 1; end
        else if (hz)                begin e_pc = 0; e_ifw = 0; e_fl = 0; end
        else                        begin e_pc = 1; e_ifw = 1; e_fl = 0; end

        chk("ctl", {pc_write, ifid_write, ifid_flush}, {e_pc, e_ifw, e_fl});
        chk("ex", {ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_jalrsel, ex_rd},
                  {m_ex.alusrc, m_ex.aluop, m_ex.branch, m_ex.jump, m_ex.jalrsel, m_ex.rd});
        chk("mem", {mem_memread, mem_memwrite, mem_regwrite, mem_rd},
                   {m_mem.memread, m_mem.memwrite, m_mem.regwrite, m_mem.rd});
        chk("wb", {wb_regwrite, wb_memtoreg, wb_pcsel, wb_rd},
                  {m_wb.regwrite, m_wb.memtoreg, m_wb.pcsel, m_wb.rd});
        chk("stall_count", 32'(stall_count), m_stalls);
        chk("fwd", {fwd_a, fwd_b}, {fsel(m_ex.rs1), fsel(m_ex.rs2)});

        if (!mr) begin
            if (redir) m_pend = 1;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (e_fl || hz) ? rec_t'('0) : dec(v, op, rs1, rs2, rd);
            m_pend = 0;
        end
        if (!e_pc && m_stalls < STALL_MAX) m_stalls++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an instruction in ID until the unit accepts it (IF/ID advances).
    task automatic issue(input bit [6:0] op, input bit [4:0] rs1,
                         input bit [4:0] rs2, input bit [4:0] rd);
        int k;
        k = 0;
        do begin
            step(1, op, rs1, rs2, rd, 0, 1);
            k++;
        end while (!e_ifw && k < 8);
        if (!e_ifw) begin
            n_cmp++; n_err++;
            $error("FAIL accept_timeout observed=stalled expected=accepted within 8 cycles");
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [6:0] ops [10];
        ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUI, 7'b1111111};

        reset = 1; id_valid = 0; id_opcode = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        ex_redirect = 0; mem_ready = 1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_regs", {ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_jalrsel, ex_rd,
                           mem_memread, mem_memwrite, mem_regwrite, mem_rd,
                           wb_regwrite, wb_memtoreg, wb_pcsel, wb_rd}, 32'd0);
        chk("reset_stall", 32'(stall_count), 32'd0);
        reset = 0;

        // Load-use: LW x5 then ADD reading x5.
        issue(OP_LW, 5'd1, 5'd0, 5'd5);
        issue(OP_R, 5'd5, 5'd2, 5'd6);
        issue(OP_I, 5'd0, 5'd0, 5'd7);
        drain(3);

        // LW to x0 never raises a hazard.
        issue(OP_LW, 5'd1, 5'd0, 5'd0);
        issue(OP_R, 5'd0, 5'd0, 5'd9);
        drain(3);

        // Taken branch in EX flushes the ADD in ID.
        issue(OP_BR, 5'd1, 5'd2, 5'd0);
        step(1, OP_R, 5'd1, 5'd2, 5'd8, 1, 1);
        drain(3);

        // Freeze for three cycles with SW in MEM and a redirect pending.
        issue(OP_SW, 5'd1, 5'd2, 5'd0);
        issue(OP_BR, 5'd0, 5'd0, 5'd0);
        repeat (3) step(1, OP_I, 5'd0, 5'd0, 5'd10, 1, 0);
        step(1, OP_I, 5'd0, 5'd0, 5'd10, 1, 1);
        drain(3);

        // x3 produced twice back to back, then consumed on both operands.
        issue(OP_R, 5'd1, 5'd2, 5'd3);
        issue(OP_R, 5'd1, 5'd2, 5'd3);
        issue(OP_R, 5'd3, 5'd3, 5'd4);
        drain(4);

        // Asynchronous reset mid-stream with LW in EX.
        issue(OP_R, 5'd1, 5'd2, 5'd11);
        issue(OP_LW, 5'd1, 5'd0, 5'd5);
        #2 reset = 1;
        #1;
        chk("midreset_regs", {ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_jalrsel, ex_rd,
                              mem_memread, mem_memwrite, mem_regwrite, mem_rd,
                              wb_regwrite, wb_memtoreg, wb_pcsel, wb_rd}, 32'd0);
        chk("midreset_stall", 32'(stall_count), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 0;

        // Randomized traffic with frequent register collisions, redirects and freezes.
        for (int i = 0; i < 700; i++) begin
            step($urandom_range(0, 9) != 0,
                 ops[$urandom_range(0, 9)],
                 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 6) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Parametrised pipelined control unit for the 5-stage RV32I core, and the successor to the single-cycle combinational decoder. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards, flushes on taken branches/jumps, freezes on data-memory wait, and counts stall cycles. It sits beside the datapath pipeline registers; datapath regs take pc_write/ifid_write from it.

Parameters:
REG_AW, 5, register-address width (rs1/rs2/rd)
ALUOP_W, 2, ALUOp width; encodings 00 LW/SW/LUI/AUIPC, 01 branch, 10 R/I, 11 JAL/JALR; upper bits 0 when ALUOP_W>2
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  core clock
reset  in  1  async active-high reset
id_valid  in  1  ID-stage instruction valid
id_opcode  in  7  instr[6:0]
id_rs1  in  REG_AW  instr rs1
id_rs2  in  REG_AW  instr rs2
id_rd  in  REG_AW  instr rd
ex_redirect  in  1  EX resolved taken branch / JAL / JALR
mem_ready  in  1  data memory can complete this cycle
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID to NOP
ex_alusrc, ex_aluop[ALUOP_W], ex_branch, ex_jump, ex_jalrsel, ex_rd[REG_AW]  out  -  ID/EX control
mem_memread, mem_memwrite, mem_regwrite, mem_rd[REG_AW]  out  -  EX/MEM control
wb_regwrite, wb_memtoreg, wb_pcsel, wb_rd[REG_AW]  out  -  MEM/WB control
stall_count  out  STALL_CNT_W  cycles with pc_write=0
fwd_a, fwd_b  out  2  forwarding selects (FORWARD_EN only)

Behaviour:
- Decode (comb, ID): R 0110011: RegWrite, ALUOp 10. I 0010011: ALUSrc, RegWrite, ALUOp 10. LW 0000011: ALUSrc, MemRead, MemtoReg, RegWrite, ALUOp 00. SW 0100011: ALUSrc, MemWrite, ALUOp 00. BR 1100011: Branch, ALUOp 01. JAL 1101111: Jump, RegWrite, PcSel(rd=PC+4), ALUOp 11. JALR 1100111: ALUSrc, JalrSel, RegWrite, PcSel, ALUOp 11. LUI/AUIPC: ALUSrc, RegWrite, ALUOp 00. Unknown opcode or id_valid=0: all-zero bubble.
- rd forwarded as 0 when RegWrite=0; writes to x0 never flagged as hazards.
- Reset: every registered output 0, stall_count 0; pc_write=ifid_write=1, ifid_flush=0 once reset deasserts. Reset mid-operation discards all in-flight control immediately (async).
- Priority per cycle: freeze > flush > load-use stall.
- Freeze: mem_ready=0 -> all three control regs hold, pc_write=ifid_write=0, ifid_flush=0; a pending ex_redirect is honoured the first cycle mem_ready=1.
- Flush: ex_redirect=1 (mem_ready=1) -> ifid_flush=1, bubble into ID/EX, EX/MEM takes EX bundle normally, pc_write=1.
- Load-use: ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2) -> pc_write=ifid_write=0, bubble into ID/EX, exactly 1 cycle.
- Latency: ID decode appears on ex_* next edge, mem_* +2, wb_* +3 (absent stalls).
- stall_count increments on every cycle with pc_write=0; saturates at all-ones, no wrap.

Optional Feature:
FORWARD_EN. Defined: fwd_a/fwd_b registered-compare EX rs1/rs2 against mem_rd (10, priority) then wb_rd (01), else 00; only load-use stalls. Undefined: fwd_a=fwd_b=00 constant; stall also while any RAW match of id_rs1/id_rs2 against a nonzero ex_rd/mem_rd with RegWrite set (up to 2 cycles).

Test Plan:
- Assert reset mid-stream with LW in EX -> all ex_/mem_/wb_ outputs 0 same cycle, stall_count 0.
- LW x5 in EX, ADD rs1=x5 in ID -> one cycle pc_write=0, ex_* bubble, ADD reaches EX next cycle, stall_count +1.
- LW x0 in EX, ADD rs1=x0 -> no stall.
- BEQ in EX with ex_redirect=1, ADD in ID -> ifid_flush=1, ex_* zero next cycle, mem_* = BEQ bundle.
- mem_ready=0 for 3 cycles with SW in MEM and ex_redirect=1 -> regs hold 3 cycles, stall_count +3, flush on cycle 4.
- FORWARD_EN: ADD x3 in MEM, SUB rs1=x3 rs2=x3 in EX, x3 also in WB -> fwd_a=fwd_b=10; undefined: same sequence stalls 2 cycles.
